// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with hardwired-zero x0, a per-register
// pending-write scoreboard and a sequential scrub engine. Define WR_BYPASS_EN for write-to-read bypass.
module register_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [XLEN-1:0]   RD1,
    output logic [XLEN-1:0]   RD2,
    output logic              RD1_busy,
    output logic              RD2_busy,
    input  logic [ADDR_W-1:0] A3,
    input  logic [XLEN-1:0]   WD3,
    input  logic              WE3,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    typedef enum logic [1:0] {IDLE, SCRUB, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  sb;
    logic              we_ok;
    logic              iss_ok;

    // Writeback and issue are only honoured while the scrub engine is idle.
    assign we_ok  = WE3 && (A3 != '0) && (state == IDLE);
    assign iss_ok = iss_valid && (iss_rd != '0) && (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = SCRUB;
                    cnt_nxt   = ADDR_W'(1);
                end
            end
            SCRUB: begin
                clr_busy = 1'b1;
                if (cnt == ADDR_W'(NREGS - 1)) state_nxt = DONE;
                else                           cnt_nxt   = cnt + ADDR_W'(1);
            end
            DONE: begin
                clr_busy  = 1'b1;
                clr_done  = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            // NOTE: the array is built from flops, not a RAM macro, so it can take the async clear.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            sb <= '0;
        end else if (state == SCRUB) begin
            regs[cnt] <= '0;
            sb[cnt]   <= 1'b0;
        end else begin
            if (we_ok) begin
                regs[A3] <= WD3;
                sb[A3]   <= 1'b0;
            end
            // Issue is applied last: a same-edge write leaves the new producer pending.
            if (iss_ok) sb[iss_rd] <= 1'b1;
        end
    end

    always_comb begin
        RD1      = (A1 == '0) ? '0 : regs[A1];
        RD1_busy = (A1 != '0) && sb[A1];
`ifdef WR_BYPASS_EN
        if (we_ok && (A3 == A1)) begin
            RD1      = WD3;
            RD1_busy = 1'b0;
        end
`endif
    end

    always_comb begin
        RD2      = (A2 == '0) ? '0 : regs[A2];
        RD2_busy = (A2 != '0) && sb[A2];
`ifdef WR_BYPASS_EN
        if (we_ok && (A3 == A2)) begin
            RD2      = WD3;
            RD2_busy = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed, table-driven bench for register_file_sb (32 x 32); bypass expectations follow WR_BYPASS_EN.
`timescale 1ns/1ps
module tb_register_file_sb;

    logic        clk;
    logic        areset;
    logic [4:0]  A1, A2, A3, iss_rd;
    logic [31:0] RD1, RD2, WD3;
    logic        RD1_busy, RD2_busy, WE3, iss_valid, clr_req, clr_busy, clr_done;
    logic        run_clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    register_file_sb #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .areset(areset),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .RD1_busy(RD1_busy), .RD2_busy(RD2_busy),
        .A3(A3), .WD3(WD3), .WE3(WE3),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    initial begin
        clk = 1'b0;
        wait (run_clk);
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        iss;
        logic [4:0]  iss_rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] rd1;
        logic        b1;
        logic [31:0] rd2;
        logic        b2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One rising edge, then 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WE3 = 1'b0; A3 = '0; WD3 = '0;
        iss_valid = 1'b0; iss_rd = '0; clr_req = 1'b0;
    endtask

    int busy_cycles;
    int done_cycles;
    int done_at;

    initial begin
        run_clk = 1'b0;
        areset  = 1'b0;
        A1 = '0; A2 = '0;
        idle_inputs();

        // Reset pulse with no clock edge.
        #1 areset = 1'b1;
        #2 areset = 1'b0;
        #1;
        check("reset clr_busy", {31'd0, clr_busy}, 32'd0);
        check("reset clr_done", {31'd0, clr_done}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            check($sformatf("reset rd1[%0d]", i), RD1, 32'd0);
            check($sformatf("reset rd2[%0d]", 31 - i), RD2, 32'd0);
            check($sformatf("reset busy[%0d]", i), {30'd0, RD1_busy, RD2_busy}, 32'd0);
        end
        run_clk = 1'b1;
        #2;

        // {we, a3, wd3, iss, iss_rd, a1, a2, rd1, b1, rd2, b2}; reads sampled after the edge.
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd5,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0,  5'd7,  5'd7,  32'h00000055, 1'b0, 32'h00000055, 1'b0};
        vecs[4] = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd9,  5'd9,  5'd7,  32'h00000099, 1'b1, 32'h00000055, 1'b0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd0,  32'h00000099, 1'b1, 32'h0,        1'b0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        1'b0, 32'h00000099, 1'b1};
        vecs[7] = '{1'b1, 5'd12, 32'hCAFE0001, 1'b0, 5'd0,  5'd12, 5'd31, 32'hCAFE0001, 1'b0, 32'h0,        1'b0};
        vecs[8] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd12, 5'd31, 5'd12, 32'hFFFFFFFF, 1'b0, 32'hCAFE0001, 1'b1};
        vecs[9] = '{1'b1, 5'd12, 32'h00000012, 1'b0, 5'd0,  5'd12, 5'd9,  32'h00000012, 1'b0, 32'h00000099, 1'b1};

        for (int v = 0; v < 10; v++) begin
            WE3 = vecs[v].we; A3 = vecs[v].a3; WD3 = vecs[v].wd3;
            iss_valid = vecs[v].iss; iss_rd = vecs[v].iss_rd;
            A1 = vecs[v].a1; A2 = vecs[v].a2;
            step();
            idle_inputs();
            #1;
            check($sformatf("vec%0d rd1", v), RD1, vecs[v].rd1);
            check($sformatf("vec%0d rd1_busy", v), {31'd0, RD1_busy}, {31'd0, vecs[v].b1});
            check($sformatf("vec%0d rd2", v), RD2, vecs[v].rd2);
            check($sformatf("vec%0d rd2_busy", v), {31'd0, RD2_busy}, {31'd0, vecs[v].b2});
        end

        // Bypass: reg 4 holds 0x11 and is pending, then written with 0x77 while being read.
        WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h11; iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        idle_inputs();
        A1 = 5'd4;
        WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h77;
        #1;
`ifdef WR_BYPASS_EN
        check("bypass same-cycle rd1", RD1, 32'h77);
        check("bypass same-cycle busy", {31'd0, RD1_busy}, 32'd0);
`else
        check("no-bypass same-cycle rd1", RD1, 32'h11);
        check("no-bypass same-cycle busy", {31'd0, RD1_busy}, 32'd1);
`endif
        step();
        idle_inputs();
        #1;
        check("bypass next-cycle rd1", RD1, 32'h77);
        check("bypass next-cycle busy", {31'd0, RD1_busy}, 32'd0);

        // Fill regs 1..31 with index*3; reg 10 also issued on the same edge.
        for (int i = 1; i < 32; i++) begin
            WE3 = 1'b1; A3 = 5'(i); WD3 = 32'(i * 3);
            iss_valid = (i == 10); iss_rd = 5'(i);
            step();
        end
        idle_inputs();
        A1 = 5'd10; A2 = 5'd30;
        #1;
        check("fill rd10", RD1, 32'd30);
        check("fill busy10", {31'd0, RD1_busy}, 32'd1);
        check("fill rd30", RD2, 32'd90);

        // Scrub with a dropped write to reg 3 and a dropped issue to reg 2.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cycles = 0; done_cycles = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!clr_busy) break;
            busy_cycles++;
            if (clr_done) begin done_cycles++; done_at = k; end
            if (k == 5) begin
                WE3 = 1'b1; A3 = 5'd3; WD3 = 32'hAA;
                iss_valid = 1'b1; iss_rd = 5'd2;
            end else begin
                idle_inputs();
            end
            if (k == 10) begin
                A1 = 5'd15; A2 = 5'd5;
                #1;
                check("mid-scrub rd15 untouched", RD1, 32'd45);
                check("mid-scrub rd5 cleared", RD2, 32'd0);
            end
            step();
        end
        idle_inputs();
        check("scrub busy cycles", 32'(busy_cycles), 32'd32);
        check("scrub done pulses", 32'(done_cycles), 32'd1);
        check("scrub done cycle", 32'(done_at), 32'd32);
        check("scrub idle after", {31'd0, clr_busy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            #1;
            check($sformatf("post-scrub rd[%0d]", i), RD1, 32'd0);
            check($sformatf("post-scrub busy[%0d]", i), {31'd0, RD1_busy}, 32'd0);
        end

        // Reset mid-scrub, then a normal write must succeed.
        step();
        WE3 = 1'b1; A3 = 5'd25; WD3 = 32'h25;
        step();
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k < 10; k++) step();
        check("pre-reset clr_busy", {31'd0, clr_busy}, 32'd1);
        areset = 1'b1;
        #1;
        check("reset mid-scrub clr_busy", {31'd0, clr_busy}, 32'd0);
        check("reset mid-scrub clr_done", {31'd0, clr_done}, 32'd0);
        A1 = 5'd25;
        #1;
        check("reset mid-scrub rd25", RD1, 32'd0);
        areset = 1'b0;
        #1;
        WE3 = 1'b1; A3 = 5'd20; WD3 = 32'hBEEF0020;
        step();
        idle_inputs();
        check("post-reset clr_busy", {31'd0, clr_busy}, 32'd0);
        A1 = 5'd20;
        #1;
        check("post-reset write rd20", RD1, 32'hBEEF0020);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the core's integer register file. Adds configurable width and depth, a hardwired-zero x0, and a per-register scoreboard of pending writes for multi-cycle/pipelined writeback. Adds a sequential scrub engine that zeroes the array without a reset. Sits between decode (reads, issue) and writeback (write port) in the RV32I datapath.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; power of two, >= 2
ADDR_W (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock; all state updates on rising edge
areset  in  1  asynchronous, active-high reset
A1  in  ADDR_W  read address 1
A2  in  ADDR_W  read address 2
RD1  out  XLEN  read data 1 (combinational)
RD2  out  XLEN  read data 2 (combinational)
RD1_busy  out  1  register A1 has a pending write
RD2_busy  out  1  register A2 has a pending write
A3  in  ADDR_W  write address
WD3  in  XLEN  write data
WE3  in  1  write enable
iss_valid  in  1  issue: mark register iss_rd pending
iss_rd  in  ADDR_W  destination register being issued
clr_req  in  1  start scrub (sampled in IDLE only)
clr_busy  out  1  scrub in progress
clr_done  out  1  one-cycle pulse when scrub completes

Behaviour:
- Reset (areset=1, async): all registers = 0, all scoreboard bits = 0, FSM = IDLE, scrub counter = 0, clr_busy = 0, clr_done = 0. RD1/RD2 therefore read 0 and RD1_busy/RD2_busy read 0.
- Reads: combinational, zero latency. RDn = regs[An]. RDn_busy = sb[An]. Address 0 always returns 0 with busy 0.
- Write: on a clock edge with WE3=1, A3!=0 and FSM=IDLE: regs[A3] <= WD3 and sb[A3] <= 0. Writes to x0 are discarded. New data is visible on RDn the cycle after the edge.
- Issue: on a clock edge with iss_valid=1, iss_rd!=0 and FSM=IDLE: sb[iss_rd] <= 1.
- Same-edge write and issue to the same register: data is written and sb stays 1, because issue wins and the new producer is pending.
- Re-issue to an already-busy register: sb stays 1. A write to a non-busy register is legal.
- FSM states:
  - IDLE: clr_req=1 -> SCRUB, counter <= 1.
  - SCRUB: each cycle regs[counter] <= 0 and sb[counter] <= 0, then counter++. When counter = NREGS-1 the register is cleared and the FSM goes to DONE.
  - DONE: clr_done=1 for exactly this cycle, then -> IDLE.
  - clr_busy = 1 in SCRUB and DONE.
  - Scrub takes NREGS-1 SCRUB cycles plus 1 DONE cycle.
- During SCRUB/DONE: WE3 and iss_valid are ignored (dropped, not queued). clr_req is ignored. Reads remain live and show partially scrubbed contents.
- areset asserted mid-scrub: immediate return to reset state; the scrub is abandoned.
- Address arithmetic is unsigned and ADDR_W bits wide. The counter never wraps past NREGS-1.

Optional Feature:
Macro WR_BYPASS_EN.
- Defined: write-to-read bypass. If WE3=1, A3!=0, FSM=IDLE and A3==An, then RDn = WD3 and RDn_busy = 0 in the same cycle. The combinational path runs from WD3 to RDn.
- Not defined: no bypass. RDn shows the old value and old busy until the edge after the write.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: pulse areset with no clock edge -> all 32 reads = 0, all busy = 0, clr_busy = 0.
- Write/read: WE3=1, A3=5, WD3=0xDEADBEEF; next cycle A1=5 -> RD1 = 0xDEADBEEF. WE3=1, A3=0, WD3=0x1234 -> A2=0 reads 0.
- Scoreboard: iss_valid with iss_rd=7 -> RD1_busy=1 at A1=7. Write A3=7 with WD3=0x55 -> next cycle busy=0 and RD1=0x55. Same-edge issue and write to 9 -> busy=1, data updated.
- Scrub: fill regs 1..31 with index*3, then pulse clr_req. Required:
  - clr_busy=1 for 32 cycles.
  - clr_done high exactly on the 32nd cycle.
  - Afterwards all reads are 0.
  - A WE3 (A3=3, WD3=0xAA) issued mid-scrub is dropped: reg 3 ends at 0.
- Reset mid-scrub: assert areset on scrub cycle 10 -> clr_busy drops immediately; a subsequent write to reg 20 succeeds.
- Bypass: WE3=1, A3=4, WD3=0x77, A1=4 in the same cycle. With WR_BYPASS_EN -> RD1=0x77 that cycle. Without it -> RD1 holds the old value and shows 0x77 the next cycle.
